hex_display_capture: RTL and testbench

//  N-digit hex display front end: registers a live bus, captures a snapshot on load,
//  and drives two parallel 7-seg banks (live and captured).

---
 rtl/hex_display_capture.sv | 153 +++++++++++++++
 tb/tb_hex_display_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_capture.sv
// hex_display_capture: hex debug display front end.
// Registers a live bus, holds a snapshot taken on load, and drives a live
// seven-segment bank, a captured bank and one time-multiplexed scan port.
// On the scan port, digits whose live value differs from the snapshot can blink.

module hex_display_capture #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   din,
    input  logic                    load,
    input  logic                    clear,
    input  logic                    show_live,
    input  logic                    blink_en,
    output logic [7*N_DIGITS-1:0]   seg_live,
    output logic [7*N_DIGITS-1:0]   seg_cap,
    output logic                    cap_valid,
    output logic [6:0]              scan_seg,
    output logic [N_DIGITS-1:0]     scan_an
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4*N_DIGITS-1:0] live_q;
    logic [4*N_DIGITS-1:0] cap;
    logic [N_DIGITS-1:0]   dirty;

    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic [FRAME_W-1:0]    frame;
    logic                  blink_phase;

    logic                  div_last;
    logic                  idx_last;
    logic                  frame_last;

    logic [3:0]            live_digit;
    logic [3:0]            cap_digit;
    logic                  dirty_sel;

    // Active-low segment pattern (bit0 = a .. bit6 = g) for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Live bus is re-registered every cycle so both banks see a clean value.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
        end else begin
            live_q <= din;
        end
    end

    // Snapshot register: clear wins over load, and every load recaptures.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap       <= '0;
            cap_valid <= 1'b0;
        end else if (clear) begin
            cap       <= '0;
            cap_valid <= 1'b0;
        end else if (load) begin
            cap       <= din;
            cap_valid <= 1'b1;
        end
    end

    assign div_last   = (div == DIV_W'(SCAN_DIV - 1));
    assign idx_last   = (idx == IDX_W'(N_DIGITS - 1));
    assign frame_last = (frame == FRAME_W'(BLINK_FRAMES - 1));

    // Scan timing chain: slot divider -> digit index -> frame count -> blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            idx         <= '0;
            frame       <= '0;
            blink_phase <= 1'b0;
        end else begin
            div <= div_last ? '0 : div + DIV_W'(1);
            if (div_last) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
                if (idx_last) begin
                    frame <= frame_last ? '0 : frame + FRAME_W'(1);
                    if (frame_last) begin
                        blink_phase <= ~blink_phase;
                    end
                end
            end
        end
    end

    // Parallel banks and per-digit dirty flags.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        assign seg_live[7*g +: 7] = hex_to_seg(live_q[4*g +: 4]);
        assign seg_cap[7*g +: 7]  = cap_valid ? hex_to_seg(cap[4*g +: 4]) : 7'h7F;
        assign dirty[g]           = cap_valid && (live_q[4*g +: 4] != cap[4*g +: 4]);
    end

    // Select the digit currently being scanned and its active-low anode.
    always_comb begin
        live_digit = 4'h0;
        cap_digit  = 4'h0;
        dirty_sel  = 1'b0;
        scan_an    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                live_digit = live_q[4*i +: 4];
                cap_digit  = cap[4*i +: 4];
                dirty_sel  = dirty[i];
                scan_an[i] = 1'b0;
            end
        end
    end

    // Scan segments: blank a dirty digit during the blink phase, else show the chosen source.
    always_comb begin
        scan_seg = 7'h7F;
        if (blink_en && blink_phase && dirty_sel) begin
            scan_seg = 7'h7F;
        end else if (show_live) begin
            scan_seg = hex_to_seg(live_digit);
        end else if (cap_valid) begin
            scan_seg = hex_to_seg(cap_digit);
        end
    end

endmodule

// File: tb/tb_hex_display_capture.sv
// tb_hex_display_capture: directed scenarios followed by randomized traffic,
// all checked against a cycle-count based reference model of the display.

module tb_hex_display_capture;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic              clk;
    logic              rst;
    logic [4*N-1:0]    din;
    logic              load;
    logic              clear;
    logic              show_live;
    logic              blink_en;
    logic [7*N-1:0]    seg_live;
    logic [7*N-1:0]    seg_cap;
    logic              cap_valid;
    logic [6:0]        scan_seg;
    logic [N-1:0]      scan_an;

    int tests_run;
    int tests_failed;

    // Reference model state: values as they should stand after the last edge.
    logic [4*N-1:0] m_live;
    logic [4*N-1:0] m_cap;
    logic           m_valid;
    int             m_t;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_capture #(
        .N_DIGITS    (N),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .load      (load),
        .clear     (clear),
        .show_live (show_live),
        .blink_en  (blink_en),
        .seg_live  (seg_live),
        .seg_cap   (seg_cap),
        .cap_valid (cap_valid),
        .scan_seg  (scan_seg),
        .scan_an   (scan_an)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare every output against what the model says it should be right now.
    task automatic checkAll();
        int          slot;
        int          phase;
        logic [3:0]  ld;
        logic [3:0]  cd;
        logic [27:0] exp_live;
        logic [27:0] exp_cap;
        logic [6:0]  exp_scan;
        logic [3:0]  exp_an;
        slot  = (m_t / SD) % N;
        phase = (m_t / (SD * N * BF)) % 2;
        for (int i = 0; i < N; i++) begin
            exp_live[7*i +: 7] = seg_tab[m_live[4*i +: 4]];
            exp_cap[7*i +: 7]  = m_valid ? seg_tab[m_cap[4*i +: 4]] : 7'h7F;
        end
        ld = m_live[4*slot +: 4];
        cd = m_cap[4*slot +: 4];
        if (blink_en && phase == 1 && m_valid && ld != cd)
            exp_scan = 7'h7F;
        else if (show_live)
            exp_scan = seg_tab[ld];
        else
            exp_scan = m_valid ? seg_tab[cd] : 7'h7F;
        exp_an = ~(4'b0001 << slot);
        checkOutput("cap_valid", 64'(cap_valid), 64'(m_valid));
        checkOutput("seg_live", 64'(seg_live), 64'(exp_live));
        checkOutput("seg_cap", 64'(seg_cap), 64'(exp_cap));
        checkOutput("scan_an", 64'(scan_an), 64'(exp_an));
        checkOutput("scan_seg", 64'(scan_seg), 64'(exp_scan));
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then check.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_live  = '0;
            m_cap   = '0;
            m_valid = 1'b0;
            m_t     = 0;
        end else begin
            if (clear) begin
                m_cap   = '0;
                m_valid = 1'b0;
            end else if (load) begin
                m_cap   = din;
                m_valid = 1'b1;
            end
            m_live = din;
            m_t++;
        end
        #1;
        checkAll();
    endtask

    // Drive a new input set just after an edge and check the combinational paths.
    task automatic applyStimulus(input logic r, input logic [15:0] d, input logic ld,
                                 input logic cl, input logic sl, input logic be);
        rst       = r;
        din       = d;
        load      = ld;
        clear     = cl;
        show_live = sl;
        blink_en  = be;
        #1;
        checkAll();
    endtask

    initial begin
        logic [15:0] rd;
        int          pick;
        tests_run    = 0;
        tests_failed = 0;
        m_live  = '0;
        m_cap   = '0;
        m_valid = 1'b0;
        m_t     = 0;
        rst       = 1'b1;
        din       = '0;
        load      = 1'b0;
        clear     = 1'b0;
        show_live = 1'b0;
        blink_en  = 1'b0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_seg_live", 64'(seg_live), 64'(28'h8102040));
        checkOutput("rst_seg_cap", 64'(seg_cap), 64'({4{7'h7F}}));
        checkOutput("rst_scan_an", 64'(scan_an), 64'(4'b1110));
        checkOutput("rst_scan_seg", 64'(scan_seg), 64'(7'h7F));

        // Capture A1F8 and free-run the scan over the captured bank.
        applyStimulus(1'b0, 16'hA1F8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("cap_A1F8", 64'(seg_cap), 64'({7'h08, 7'h79, 7'h0E, 7'h00}));
        applyStimulus(1'b0, 16'hA1F8, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();

        // Clear beats load, then load alone recaptures.
        applyStimulus(1'b0, 16'h5A5A, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("clear_wins", 64'(cap_valid), 64'(1'b0));
        applyStimulus(1'b0, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("load_after_clear", 64'(cap_valid), 64'(1'b1));

        // Single dirty digit with blinking on, then off.
        applyStimulus(1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h1204, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) tick();
        applyStimulus(1'b0, 16'h1204, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        applyStimulus(1'b0, 16'h1204, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) tick();

        // Reset in the middle of a scan slot (idx=2, div=3).
        for (int i = 0; i < 16 && (m_t % 16) != 11; i++) tick();
        applyStimulus(1'b1, 16'h1204, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("midscan_rst_an", 64'(scan_an), 64'(4'b1110));
        checkOutput("midscan_rst_valid", 64'(cap_valid), 64'(1'b0));

        // Randomized traffic; live data mostly stays near the snapshot.
        for (int i = 0; i < 2000; i++) begin
            pick = int'($urandom_range(0, 9));
            rd   = m_cap;
            if (pick < 5)
                rd[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
            else if (pick < 8)
                rd = 16'($urandom);
            applyStimulus($urandom_range(0, 199) == 0, rd,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                          (i % 300) < 150 ? 1'($urandom) : 1'b0,
                          $urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
